// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch preset path: converter FSM states,
// BCD correction constants and default converter dimensions.
package stopwatch_pkg;

    localparam int NUM_DIGITS_DEF = 6;
    localparam int BIN_WIDTH_DEF  = 20;

    localparam logic [3:0] BCD_MAX         = 4'd9;
    localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
    localparam logic [3:0] BCD_CORR        = 4'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_nibble_correct.sv
// Reverse double-dabble digit correction: after the right shift, a nibble
// that reads 8 or more received a carried-in '1' worth 8 instead of 5, so
// 3 is taken back. Pure 4-bit unsigned arithmetic, no inter-nibble borrow.
module bcd_nibble_correct
    import stopwatch_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // Subtract 3 from any shifted nibble at or above the threshold
    always_comb begin
        nib_out = (nib_in >= BCD_CORR_THRESH) ? (nib_in - BCD_CORR) : nib_in;
    end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result
// bit per clock, start/busy/done handshake. Turns the preset time entered
// on switches/keys into the binary count the stopwatch counter loads.
// Optional build macro BCD_CHECK_EN: reject inputs holding a nibble > 9
// with err=1 and bin_out=0 after a single cycle; otherwise err is tied 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; bcd_in sampled when start is accepted
// CONVERT | one shift+correct per clock, BIN_WIDTH iterations
// DONE    | done pulse cycle; start ignored, returns to IDLE
module bcd_to_bin_converter
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int BIN_WIDTH  = BIN_WIDTH_DEF
) (
    input  logic                    clock,
    input  logic                    Reset_n,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [BIN_WIDTH-1:0]    bin_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

    state_t               state_q, state_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BIN_WIDTH-1:0] bin_out_q, bin_out_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [BCD_W-1:0]     shift_bcd;
    logic [BCD_W-1:0]     corr_bcd;
    logic [BIN_WIDTH-1:0] shift_bin;

    // {bcd, bin} shifted right by one as a single long register
    assign shift_bcd = {1'b0, bcd_q[BCD_W-1:1]};
    assign shift_bin = {bcd_q[0], bin_q[BIN_WIDTH-1:1]};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_corr
        bcd_nibble_correct u_corr (
            .nib_in  (shift_bcd[4*g +: 4]),
            .nib_out (corr_bcd[4*g +: 4])
        );
    end

`ifdef BCD_CHECK_EN
    logic bad_in;
    logic bad_q, bad_d;
    logic err_q, err_d;

    // Flag any digit of the incoming value that is not a decimal digit
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX) bad_in = 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and next-output logic for the handshake and iteration
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        bin_out_d = bin_out_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef BCD_CHECK_EN
        bad_d     = bad_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
`ifdef BCD_CHECK_EN
                    bad_d   = bad_in;
`endif
                end
            end
            CONVERT: begin
`ifdef BCD_CHECK_EN
                // An invalid input spends exactly one cycle here, then reports
                if (bad_q) begin
                    bin_out_d = '0;
                    err_d     = 1'b1;
                    bad_d     = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else begin
`else
                begin
`endif
                    bcd_d   = corr_bcd;
                    bin_d   = shift_bin;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_ITER) begin
                        bin_out_d = shift_bin;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = DONE;
`ifdef BCD_CHECK_EN
                        err_d     = 1'b0;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            bin_out_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_CHECK_EN
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            bin_out_q <= bin_out_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BCD_CHECK_EN
            bad_q     <= bad_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bin_out = bin_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Bench for bcd_to_bin_converter: decimal-arithmetic reference model with a
// per-cycle compare, directed scenarios with literal results, and a
// randomized start/data phase.
module tb_bcd_to_bin_converter;

    logic        clock;
    logic        Reset_n;
    logic        start;
    logic [23:0] bcd_in;
    logic [19:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_to_bin_converter dut (
        .clock   (clock),
        .Reset_n (Reset_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int bcd2int(input logic [23:0] v);
        int r;
        r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic has_bad(input logic [23:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 6; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Reference model: m_t = clock edges elapsed since the accepting edge
    int          m_t   = -1;
    int          m_len = 20;
    logic        m_bad = 1'b0;
    logic [19:0] m_val = '0;
    logic [19:0] m_bin = '0;
    logic        m_err = 1'b0;

    always @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_t   = -1;
            m_bin = '0;
            m_err = 1'b0;
        end else if (m_t < 0 || m_t > m_len) begin
            if (start) begin
                m_t   = 0;
                m_val = 20'(bcd2int(bcd_in));
`ifdef BCD_CHECK_EN
                m_bad = has_bad(bcd_in);
`else
                m_bad = 1'b0;
`endif
                m_len = m_bad ? 1 : 20;
            end else begin
                m_t = -1;
            end
        end else begin
            m_t++;
            if (m_t == m_len) begin
                m_bin = m_bad ? 20'd0 : m_val;
                m_err = m_bad;
            end
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clock) begin
        check("model_busy", 32'(busy), 32'(m_t >= 0 && m_t < m_len));
        check("model_done", 32'(done), 32'(m_t == m_len));
        check("model_bin",  32'(bin_out), 32'(m_bin));
        check("model_err",  32'(err), 32'(m_err));
    end

    task automatic run_conv(input logic [23:0] v, input logic [23:0] v_late,
                            input logic [19:0] exp_bin, input int exp_busy,
                            input logic exp_err, input string tag);
        logic got;
        int   nb;
        got = 1'b0;
        nb  = 0;
        start  = 1'b1;
        bcd_in = v;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 3) bcd_in = v_late;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nb++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clock);
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int nd;
        Reset_n = 1'b0;
        start   = 1'b0;
        bcd_in  = '0;
        repeat (3) @(negedge clock);
        check("rst_bin",  32'(bin_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        Reset_n = 1'b1;
        @(negedge clock);

        run_conv(24'h999999, 24'h999999, 20'hF423F, 20, 1'b0, "max");
        run_conv(24'h123456, 24'h123456, 20'h1E240, 20, 1'b0, "v123456");
        run_conv(24'h000000, 24'h000000, 20'h00000, 20, 1'b0, "zero");

        // start held high: one accepted conversion every 22 cycles
        start  = 1'b1;
        bcd_in = 24'h001000;
        nd = 0;
        repeat (100) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("held_done_count", 32'(nd), 32'd4);
        check("held_bin", 32'(bin_out), 32'h003E8);
        start = 1'b0;
        repeat (30) @(negedge clock);

        // reset in the middle of a conversion
        start  = 1'b1;
        bcd_in = 24'h123456;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_bin",  32'(bin_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err",  32'(err), 32'd0);
        repeat (2) @(negedge clock);
        Reset_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("midrst_no_done", 32'(nd), 32'd0);
        run_conv(24'h000042, 24'h000042, 20'h0002A, 20, 1'b0, "after_rst");

        run_conv(24'h000007, 24'h999999, 20'h00007, 20, 1'b0, "late_change");

`ifdef BCD_CHECK_EN
        run_conv(24'h00A000, 24'h00A000, 20'h00000, 1, 1'b1, "invalid");
        run_conv(24'h000005, 24'h000005, 20'h00005, 20, 1'b0, "valid_after_inv");
`endif

        // randomized starts and data, checked by the model every cycle
        repeat (600) begin
            @(negedge clock);
            start  = ($urandom_range(0, 3) == 0);
            bcd_in = rand_bcd();
`ifdef BCD_CHECK_EN
            if ($urandom_range(0, 7) == 0) bcd_in[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
`endif
        end
        start = 1'b0;
        repeat (30) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
